// File: rtl/reg_file_2r1w_if.sv
// Bus bundle for reg_file_2r1w: one write port and two independent read ports.
// The master drives addresses/write data; the register bank (slave) returns read data and valid flags.
interface reg_file_2r1w_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [DATA_W-1:0] rd_data_a;
    logic              rd_vld_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_b;
    logic              rd_vld_b;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_vld_a, rd_data_b, rd_vld_b
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_vld_a, rd_data_b, rd_vld_b
    );
endinterface

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: NUM_REGS x DATA_W register bank, one synchronous write port, two combinational
// read ports with write-first forwarding and per-register valid flags. Macro REG_ZERO_EN hardwires r0.
module reg_file_2r1w #(
    parameter int                DATA_W    = 8,
    parameter int                NUM_REGS  = 4,
    parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}}
) (
    input logic            clk,
    input logic            rst,
    reg_file_2r1w_if.slave bus
);
    localparam int              ADDR_W    = $clog2(NUM_REGS);
    localparam logic [ADDR_W:0] REG_COUNT = (ADDR_W+1)'(NUM_REGS);
`ifdef REG_ZERO_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic [DATA_W-1:0]   mem [NUM_REGS];
    logic [NUM_REGS-1:0] valid;
    logic                wr_hit;

    // Extra top bit keeps the compare meaningful when NUM_REGS is a power of two.
    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return {1'b0, addr} < REG_COUNT;
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return ZERO_EN && (addr == '0);
    endfunction

    // A write only counts when it will really land; reset discards it, and it is not forwarded.
    assign wr_hit = bus.wr_en && !rst && in_range(bus.wr_addr) && !is_zero_reg(bus.wr_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= RESET_VAL;
            end
            valid <= '0;
        end else if (wr_hit) begin
            mem[bus.wr_addr]   <= bus.wr_data;
            valid[bus.wr_addr] <= 1'b1;
        end
    end

    always_comb begin
        bus.rd_data_a = '0;
        bus.rd_vld_a  = 1'b0;
        if (is_zero_reg(bus.rd_addr_a)) begin
            bus.rd_vld_a = 1'b1;
        end else if (in_range(bus.rd_addr_a)) begin
            if (wr_hit && (bus.wr_addr == bus.rd_addr_a)) begin
                bus.rd_data_a = bus.wr_data;
                bus.rd_vld_a  = 1'b1;
            end else begin
                bus.rd_data_a = mem[bus.rd_addr_a];
                bus.rd_vld_a  = valid[bus.rd_addr_a];
            end
        end
    end

    always_comb begin
        bus.rd_data_b = '0;
        bus.rd_vld_b  = 1'b0;
        if (is_zero_reg(bus.rd_addr_b)) begin
            bus.rd_vld_b = 1'b1;
        end else if (in_range(bus.rd_addr_b)) begin
            if (wr_hit && (bus.wr_addr == bus.rd_addr_b)) begin
                bus.rd_data_b = bus.wr_data;
                bus.rd_vld_b  = 1'b1;
            end else begin
                bus.rd_data_b = mem[bus.rd_addr_b];
                bus.rd_vld_b  = valid[bus.rd_addr_b];
            end
        end
    end
endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w: a power-of-two bank (4 regs) and a non-power-of-two
// bank (5 regs) driven in lockstep, checked against a behavioural model through a scoreboard queue.
module tb_reg_file_2r1w;
`ifdef REG_ZERO_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_file_2r1w_if #(.DATA_W(8), .ADDR_W(2)) bus4 ();
    reg_file_2r1w_if #(.DATA_W(8), .ADDR_W(3)) bus5 ();

    reg_file_2r1w #(.DATA_W(8), .NUM_REGS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    reg_file_2r1w #(.DATA_W(8), .NUM_REGS(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

    typedef struct {
        string      tag;
        int         dut;
        int         port;
        logic [7:0] data;
        logic       vld;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_mem [2][8];
    logic       model_vld [2][8];
    bit         model_ready = 1'b0;

    function automatic int nregs(input int d);
        return (d == 0) ? 4 : 5;
    endfunction

    function automatic int amask(input int d);
        return (d == 0) ? 3 : 7;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Expected read result; outputs are unknown before the first reset and during reset except for a hardwired r0.
    function automatic void predict(input int d, input int addr, input logic r, input logic wen,
                                    input int wa, input logic [7:0] wd,
                                    output bit known, output logic [7:0] data, output logic vld);
        int a;
        int w;
        a     = addr & amask(d);
        w     = wa & amask(d);
        known = !r && model_ready;
        data  = '0;
        vld   = 1'b0;
        if (ZERO_EN && a == 0) begin
            known = 1'b1;
            vld   = 1'b1;
        end else if (a < nregs(d)) begin
            if (!r && wen && w == a) begin
                data = wd;
                vld  = 1'b1;
            end else begin
                data = model_mem[d][a];
                vld  = model_vld[d][a];
            end
        end
    endfunction

    task automatic applyStimulus(input string tag, input logic r, input logic wen, input int wa,
                                 input logic [7:0] wd, input int ra, input int rb);
        bit         known;
        logic [7:0] data;
        logic       vld;
        exp_t       e;
        logic [7:0] act_data;
        logic       act_vld;
        int         w;
        @(negedge clk);
        rst            = r;
        bus4.wr_en     = wen;
        bus4.wr_addr   = 2'(wa);
        bus4.wr_data   = wd;
        bus4.rd_addr_a = 2'(ra);
        bus4.rd_addr_b = 2'(rb);
        bus5.wr_en     = wen;
        bus5.wr_addr   = 3'(wa);
        bus5.wr_data   = wd;
        bus5.rd_addr_a = 3'(ra);
        bus5.rd_addr_b = 3'(rb);
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                predict(d, (p == 0) ? ra : rb, r, wen, wa, wd, known, data, vld);
                if (known) begin
                    e.tag  = tag;
                    e.dut  = d;
                    e.port = p;
                    e.data = data;
                    e.vld  = vld;
                    sb.push_back(e);
                end
            end
        end
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.dut == 0) begin
                act_data = (e.port == 0) ? bus4.rd_data_a : bus4.rd_data_b;
                act_vld  = (e.port == 0) ? bus4.rd_vld_a  : bus4.rd_vld_b;
            end else begin
                act_data = (e.port == 0) ? bus5.rd_data_a : bus5.rd_data_b;
                act_vld  = (e.port == 0) ? bus5.rd_vld_a  : bus5.rd_vld_b;
            end
            checkOutput($sformatf("%s n%0d %s data", e.tag, nregs(e.dut), (e.port == 0) ? "A" : "B"),
                        32'(act_data), 32'(e.data));
            checkOutput($sformatf("%s n%0d %s vld", e.tag, nregs(e.dut), (e.port == 0) ? "A" : "B"),
                        32'(act_vld), 32'(e.vld));
        end
        @(posedge clk);
        if (r) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 8; i++) begin
                    model_mem[d][i] = 8'h00;
                    model_vld[d][i] = 1'b0;
                end
            end
            model_ready = 1'b1;
        end else if (wen) begin
            for (int d = 0; d < 2; d++) begin
                w = wa & amask(d);
                if (w < nregs(d) && !(ZERO_EN && w == 0)) begin
                    model_mem[d][w] = wd;
                    model_vld[d][w] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus4.wr_en = 1'b0; bus4.wr_addr = '0; bus4.wr_data = '0; bus4.rd_addr_a = '0; bus4.rd_addr_b = '0;
        bus5.wr_en = 1'b0; bus5.wr_addr = '0; bus5.wr_data = '0; bus5.rd_addr_a = '0; bus5.rd_addr_b = '0;
        $display("[TB] starting, REG_ZERO_EN=%0d", ZERO_EN);

        applyStimulus("reset",     1'b1, 1'b0, 0, 8'h00, 0, 1);
        applyStimulus("post_rst",  1'b0, 1'b0, 0, 8'h00, 0, 1);
        applyStimulus("post_rst",  1'b0, 1'b0, 0, 8'h00, 2, 3);
        applyStimulus("post_rst",  1'b0, 1'b0, 0, 8'h00, 4, 4);

        applyStimulus("wr_r2",     1'b0, 1'b1, 2, 8'hA5, 0, 1);
        applyStimulus("rd_r2",     1'b0, 1'b0, 0, 8'h00, 2, 2);

        applyStimulus("fwd_r3",    1'b0, 1'b1, 3, 8'h3C, 3, 1);
        applyStimulus("rd_r3",     1'b0, 1'b0, 0, 8'h00, 3, 3);

        applyStimulus("wr_r1",     1'b0, 1'b1, 1, 8'h55, 1, 2);
        applyStimulus("rst_prio",  1'b1, 1'b1, 1, 8'hFF, 1, 2);
        applyStimulus("after_rst", 1'b0, 1'b0, 0, 8'h00, 1, 2);

        applyStimulus("wr_r4",     1'b0, 1'b1, 4, 8'h44, 4, 0);
        applyStimulus("oor_wr6",   1'b0, 1'b1, 6, 8'h77, 6, 4);
        applyStimulus("oor_rd",    1'b0, 1'b0, 0, 8'h00, 6, 5);
        applyStimulus("oor_rd",    1'b0, 1'b0, 0, 8'h00, 7, 2);

        applyStimulus("wr_r0",     1'b0, 1'b1, 0, 8'h11, 0, 0);
        applyStimulus("rd_r0",     1'b0, 1'b0, 0, 8'h00, 0, 1);

        applyStimulus("b2b_1",     1'b0, 1'b1, 2, 8'h10, 2, 2);
        applyStimulus("b2b_2",     1'b0, 1'b1, 2, 8'h20, 2, 3);
        applyStimulus("b2b_rd",    1'b0, 1'b0, 0, 8'h00, 2, 2);
        applyStimulus("wen_off",   1'b0, 1'b0, 2, 8'hEE, 2, 1);

        for (int i = 0; i < 60; i++) begin
            applyStimulus($sformatf("rand%0d", i), ($urandom_range(15) == 0), 1'($urandom_range(1)),
                          int'($urandom_range(7)), 8'($urandom), int'($urandom_range(7)),
                          int'($urandom_range(7)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
